quadric_root_engine: RTL
========================

Name: quadric_root_engine

Overview:
Parametrised successor to the discriminant/root-finder pair. It solves a*x^2 + b*x + c = 0 for signed fixed-point coefficients of width W. It accepts one coefficient set per transaction over a valid/ready handshake and computes the discriminant exactly. It then takes an iterative integer square root and returns sign-normalised root numerators over a positive denominator, plus hit/exact/degenerate flags and a pass-through tag. It sits between ray/surface coefficient generation and the hit-sort stage; division is left to the consumer.

Parameters:
W, 16, coefficient width (signed two's complement), W >= 4
TAG_W, 4, width of opaque tag carried from input to output

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-high reset
in_valid  input  1  coefficient set present
in_ready  output  1  engine can accept (high only in IDLE)
a  input  W  quadratic coefficient, signed
b  input  W  linear coefficient, signed
c  input  W  constant coefficient, signed
in_tag  input  TAG_W  opaque tag
out_valid  output  1  result present
out_ready  input  1  consumer accepts result
root_lo_num  output  W+2  signed numerator of smaller root
root_hi_num  output  W+2  signed numerator of larger root
denom  output  W+2  unsigned denominator, always > 0 when hit=1
hit  output  1  real root(s) exist
exact  output  1  sqrt(D) exact (s*s == D)
degenerate  output  1  a == 0 (linear case)
out_tag  output  TAG_W  tag of this result

Behaviour:
- Reset: one clock, active-high, synchronous; reset is sampled only on the rising edge of clk. It forces state IDLE and zeroes all outputs (in_ready=1 once in IDLE, out_valid=0). Reset mid-transaction discards the transaction; no output is produced for it.
- States: IDLE, MUL, SQRT, DONE.
- IDLE: in_ready=1. On in_valid&&in_ready, latch a, b, c, in_tag and normalise signs: if a<0, negate a, b and c (widen to W+1 bits so -(-2^(W-1)) is representable). Go to MUL.
- MUL, one cycle: D = b'^2 - 4*a'*c', signed, 2W+2 bits, exact with no overflow.
  - If a'==0, go to DONE with degenerate=1.
  - Else if D<0, go to DONE with hit=0.
  - Else load the sqrt engine and go to SQRT.
- SQRT: restoring digit-by-digit integer square root, one result bit per cycle, exactly W+1 cycles. Result s = floor(sqrt(D)), W+1 bits unsigned. Then go to DONE.
- DONE outputs (registered, stable while out_valid && !out_ready):
  - Normal case: root_lo_num = -b' - s, root_hi_num = -b' + s, denom = 2a', hit=1, exact=(s*s==D), degenerate=0.
  - D<0: hit=0, exact=0, numerators=0, denom=2a'.
  - Degenerate case: if b'==0, hit=0 and all values 0. Else hit=1, exact=1, and the sign is normalised so denom=|b'|; root_lo_num = root_hi_num = -c'*sign(b').
  - out_tag = latched tag in all cases.
- On out_valid && out_ready, return to IDLE on that edge; out_valid drops the next cycle.
- in_ready and out_valid are never high together. Back-to-back acceptance is not possible.
- Latency, counted in edges from the accepting edge to the first cycle with out_valid=1:
  - Normal path: W+2 edges (1 MUL + W+1 SQRT).
  - Early exit (D<0 or a==0): 1 edge.
- Throughput with out_ready held high: one transaction per W+4 cycles (normal) or 3 cycles (early exit).
- Inputs are ignored outside IDLE. in_valid may toggle freely without effect.

Test Plan:
- W=8, a=1, b=-3, c=2 -> after 10 edges: lo=2, hi=4, denom=2, hit=1, exact=1 (roots 1, 2).
- W=8, a=-1, b=3, c=-2 -> identical outputs to the previous case (sign normalisation); a=1, b=0, c=-5 -> D=20, lo=-4, hi=4, denom=2, exact=0.
- W=8, a=1, b=2, c=5 -> D=-16, out_valid 1 edge after accept, hit=0, numerators 0; a=0, b=-2, c=4 -> degenerate=1, denom=2, lo=hi=4; a=0, b=0 -> hit=0.
- W=8 extremes a=-128, b=-128, c=127 -> D=81408, s=285, lo=-413, hi=157, denom=256, exact=0; no overflow.
- Hold out_ready=0 for 5 cycles in DONE -> outputs and out_tag stable, in_ready=0; then pulse out_ready -> IDLE next cycle. Random back-to-back tags (0..15) must come out in order.
- Assert reset during SQRT -> next cycle in IDLE with all outputs 0. The interrupted tag never appears, and the following transaction completes normally.

Source files
------------

// File: rtl/quadric_root_engine.sv
// Quadratic root engine: exact discriminant of a*x^2 + b*x + c, iterative integer sqrt,
// and sign-normalised root numerators over a positive denominator.
module quadric_root_engine #(
    parameter int unsigned W     = 16,
    parameter int unsigned TAG_W = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic signed [W-1:0]     a,
    input  logic signed [W-1:0]     b,
    input  logic signed [W-1:0]     c,
    input  logic [TAG_W-1:0]        in_tag,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [W+1:0]     root_lo_num,
    output logic signed [W+1:0]     root_hi_num,
    output logic [W+1:0]            denom,
    output logic                    hit,
    output logic                    exact,
    output logic                    degenerate,
    output logic [TAG_W-1:0]        out_tag
);

    localparam int unsigned CW    = W + 1;
    localparam int unsigned DW    = 2 * W + 2;
    localparam int unsigned RW    = W + 2;
    localparam int unsigned REM_W = W + 2;
    localparam int unsigned CNT_W = $clog2(W + 2);

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        SQRT,
        DONE
    } state_t;

    state_t state;
    state_t state_next;

    logic signed [CW-1:0] a_n;
    logic signed [CW-1:0] b_n;
    logic signed [CW-1:0] c_n;
    logic [TAG_W-1:0]     tag_q;

    logic [DW-1:0]        rad_q;
    logic [REM_W-1:0]     rem_q;
    logic [CW-1:0]        root_q;
    logic [CNT_W-1:0]     cnt_q;

    logic signed [DW-1:0] bb;
    logic signed [DW-1:0] ac4;
    logic signed [DW-1:0] d_c;
    logic [REM_W+1:0]     rem_sh;
    logic [REM_W+1:0]     trial;
    logic [REM_W+1:0]     rem_nx;
    logic [CW-1:0]        root_nx;
    logic                 sqrt_last;

    logic signed [RW-1:0] b_w;
    logic signed [RW-1:0] c_w;
    logic signed [RW-1:0] s_w;
    logic [CW-1:0]        abs_b;

    // Exact discriminant; 2W+2 bits covers b'^2 + 4*|a'*c'| without overflow
    always_comb begin
        bb  = DW'(b_n) * DW'(b_n);
        ac4 = (DW'(a_n) * DW'(c_n)) <<< 2;
        d_c = bb - ac4;
    end

    // One restoring square-root step: bring down two radicand bits, try (2*root+1)
    always_comb begin
        rem_sh    = {rem_q, rad_q[DW-1 -: 2]};
        trial     = {1'b0, root_q, 2'b01};
        rem_nx    = rem_sh;
        root_nx   = {root_q[CW-2:0], 1'b0};
        if (rem_sh >= trial) begin
            rem_nx  = rem_sh - trial;
            root_nx = {root_q[CW-2:0], 1'b1};
        end
        sqrt_last = (cnt_q == CNT_W'(W));
    end

    always_comb begin
        b_w   = RW'(b_n);
        c_w   = RW'(c_n);
        s_w   = $signed({1'b0, root_nx});
        abs_b = b_n[CW-1] ? -b_n : b_n;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    state_next = MUL;
                end
            end
            MUL: begin
                if ((a_n == '0) || d_c[DW-1]) begin
                    state_next = DONE;
                end else begin
                    state_next = SQRT;
                end
            end
            SQRT: begin
                if (sqrt_last) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Handshake flags track the state being entered, so they are exact from the edge
    always_ff @(posedge clk) begin
        if (reset) begin
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            in_ready  <= (state_next == IDLE);
            out_valid <= (state_next == DONE);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            a_n         <= '0;
            b_n         <= '0;
            c_n         <= '0;
            tag_q       <= '0;
            rad_q       <= '0;
            rem_q       <= '0;
            root_q      <= '0;
            cnt_q       <= '0;
            root_lo_num <= '0;
            root_hi_num <= '0;
            denom       <= '0;
            hit         <= 1'b0;
            exact       <= 1'b0;
            degenerate  <= 1'b0;
            out_tag     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        tag_q <= in_tag;
                        if (a[W-1]) begin
                            a_n <= -CW'(a);
                            b_n <= -CW'(b);
                            c_n <= -CW'(c);
                        end else begin
                            a_n <= CW'(a);
                            b_n <= CW'(b);
                            c_n <= CW'(c);
                        end
                    end
                end
                MUL: begin
                    rad_q   <= d_c;
                    rem_q   <= '0;
                    root_q  <= '0;
                    cnt_q   <= '0;
                    out_tag <= tag_q;
                    if (a_n == '0) begin
                        // Linear case: single root -c/b, sign folded into the numerator
                        degenerate <= 1'b1;
                        if (b_n == '0) begin
                            hit         <= 1'b0;
                            exact       <= 1'b0;
                            denom       <= '0;
                            root_lo_num <= '0;
                            root_hi_num <= '0;
                        end else begin
                            hit         <= 1'b1;
                            exact       <= 1'b1;
                            denom       <= RW'(abs_b);
                            root_lo_num <= b_n[CW-1] ? c_w : -c_w;
                            root_hi_num <= b_n[CW-1] ? c_w : -c_w;
                        end
                    end else if (d_c[DW-1]) begin
                        degenerate  <= 1'b0;
                        hit         <= 1'b0;
                        exact       <= 1'b0;
                        denom       <= {a_n, 1'b0};
                        root_lo_num <= '0;
                        root_hi_num <= '0;
                    end
                end
                SQRT: begin
                    rad_q  <= {rad_q[DW-3:0], 2'b00};
                    rem_q  <= rem_nx[REM_W-1:0];
                    root_q <= root_nx;
                    cnt_q  <= cnt_q + CNT_W'(1);
                    if (sqrt_last) begin
                        degenerate  <= 1'b0;
                        hit         <= 1'b1;
                        exact       <= (rem_nx == '0);
                        denom       <= {a_n, 1'b0};
                        root_lo_num <= -b_w - s_w;
                        root_hi_num <= -b_w + s_w;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
